// File: rtl/wb_initiator_pkg.sv
// Shared types for the single-outstanding Wishbone initiator.
// Status codes match the bridge software header.
package wb_initiator_pkg;

  localparam logic [1:0] WBI_OK      = 2'b00;
  localparam logic [1:0] WBI_ERR     = 2'b01;
  localparam logic [1:0] WBI_RTY_EXH = 2'b10;
  localparam logic [1:0] WBI_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    GAP,
    RESP
  } t_wbi_state;

  typedef enum logic [1:0] {
    ST_OK  = WBI_OK,
    ST_ERR = WBI_ERR,
    ST_RTY = WBI_RTY_EXH,
    ST_TMO = WBI_TIMEOUT
  } t_wbi_status;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone pipelined single-outstanding master with
// bounded retry, timeout and valid/ready response port.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int RETRIES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [31:0]       cmd_dat,
  input  logic [3:0]        cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_dat,
  output logic [1:0]        rsp_status,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  input  logic              wb_stall_i
);

  localparam int TMO_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RTY_W =
    (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX =
    TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RTY_W-1:0] RTY_MAX =
    RTY_W'(RETRIES);

  t_wbi_state       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             take, busy, tmo_hit, fin;
  t_wbi_status      fin_status;
  logic [31:0]      fin_dat;

  assign take = cmd_valid && cmd_ready && (state_q == IDLE);
  assign busy = (state_q == REQ) || (state_q == WAIT)
             || (state_q == GAP);
  assign tmo_hit = (TIMEOUT != 0) && busy
                && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    rty_d      = rty_q;
    fin        = 1'b0;
    fin_status = ST_OK;
    fin_dat    = 32'd0;
    if (busy && tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = REQ;
          tmo_d   = '0;
          rty_d   = '0;
        end
      end
      REQ: if (!wb_stall_i) state_d = WAIT;
      WAIT: begin
        if (wb_err_i) begin
          fin        = 1'b1;
          fin_status = ST_ERR;
        end else if (wb_rty_i) begin
          if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + 1'b1;
            state_d = GAP;
          end else begin
            fin        = 1'b1;
            fin_status = ST_RTY;
          end
        end else if (wb_ack_i) begin
          fin     = 1'b1;
          fin_dat = wb_we_o ? 32'd0 : wb_dat_i;
        end
      end
      GAP:  state_d = REQ;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A real termination in the abort cycle still wins.
    if (tmo_hit && !fin) begin
      fin        = 1'b1;
      fin_status = ST_TMO;
      fin_dat    = 32'd0;
    end
    if (fin) state_d = RESP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      rty_q      <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      rsp_dat    <= '0;
      rsp_status <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      rty_q     <= rty_d;
      cmd_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      wb_cyc_o  <= (state_d == REQ) || (state_d == WAIT);
      wb_stb_o  <= (state_d == REQ);
      if (take) begin
        wb_we_o  <= cmd_we;
        wb_adr_o <= cmd_adr;
        wb_dat_o <= cmd_dat;
        wb_sel_o <= cmd_sel;
      end
      if (fin) begin
        rsp_status <= fin_status;
        rsp_dat    <= fin_dat;
      end
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator.
// Slave responses are driven inline per scenario.
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_initiator #(
    .ADDR_W(32), .TIMEOUT(16), .RETRIES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_stall_i(wb_stall_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_rty_i   = 1'b0;
    wb_stall_i = 1'b0;
  endtask

  // Returns in the first REQ cycle.
  task automatic issue(input logic we,
                       input logic [31:0] adr,
                       input logic [31:0] dat,
                       input logic [3:0] sel);
    cmd_we = we; cmd_adr = adr;
    cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1;
    for (int i = 0; i < 30 && !cmd_ready; i++) step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got=%b exp=1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks += 5;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready);
    end
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid);
    end
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_ctl got=%b exp=000",
               {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'd0) begin
      errors++;
      $display("FAIL rst_fields got=%h exp=0",
               {wb_adr_o, wb_dat_o, wb_sel_o});
    end
    if ({rsp_dat, rsp_status} !== 34'd0) begin
      errors++;
      $display("FAIL rst_rsp got=%h exp=0", {rsp_dat, rsp_status});
    end
  endtask

  task automatic test_read();
    int stbn = 0;
    int waitn = 0;
    wb_dat_i = 32'hDEADBEEF;
    issue(1'b0, 32'h0000_4000, 32'h0, 4'hF);
    checks++;
    if (wb_adr_o !== 32'h0000_4000 || wb_we_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_adr got=%h exp=00004000", wb_adr_o);
    end
    for (int i = 0; i < 20; i++) begin
      if (wb_stb_o) stbn++;
      if (wb_cyc_o && !wb_stb_o) waitn++;
      wb_ack_i = wb_cyc_o && !wb_stb_o && (waitn == 3);
      if (rsp_valid) break;
      step();
    end
    wb_ack_i = 1'b0;
    checks += 4;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rd_done got=%b exp=1", rsp_valid);
    end
    if (rsp_dat !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_dat got=%h exp=deadbeef", rsp_dat);
    end
    if (rsp_status !== 2'b00) begin
      errors++; $display("FAIL rd_status got=%b exp=00", rsp_status);
    end
    if (stbn != 1) begin
      errors++; $display("FAIL rd_stb_cycles got=%0d exp=1", stbn);
    end
    step();
  endtask

  task automatic test_write_stall();
    int  stbn = 0;
    logic bad = 1'b0;
    wb_dat_i = 32'hFFFF_FFFF;
    issue(1'b1, 32'h0000_0100, 32'h12345678, 4'b0101);
    for (int i = 0; i < 20; i++) begin
      if (wb_stb_o) begin
        stbn++;
        if (wb_adr_o !== 32'h100 || wb_dat_o !== 32'h12345678
            || wb_sel_o !== 4'b0101 || wb_we_o !== 1'b1
            || wb_cyc_o !== 1'b1)
          bad = 1'b1;
      end
      wb_stall_i = wb_stb_o && (stbn <= 3);
      wb_ack_i   = wb_cyc_o && !wb_stb_o;
      if (rsp_valid) break;
      step();
    end
    slave_idle();
    checks += 5;
    if (stbn != 4) begin
      errors++; $display("FAIL wr_stb_cycles got=%0d exp=4", stbn);
    end
    if (bad) begin
      errors++; $display("FAIL wr_fields_stable got=1 exp=0");
    end
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL wr_done got=%b exp=1", rsp_valid);
    end
    if (rsp_status !== 2'b00) begin
      errors++; $display("FAIL wr_status got=%b exp=00", rsp_status);
    end
    if (rsp_dat !== 32'd0) begin
      errors++; $display("FAIL wr_dat got=%h exp=0", rsp_dat);
    end
    step();
  endtask

  task automatic test_retry();
    int   pulses = 0;
    int   gaps = 0;
    logic prev = 1'b0;
    wb_dat_i = 32'hAAAA_5555;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    for (int i = 0; i < 40; i++) begin
      if (wb_stb_o && !prev) pulses++;
      prev = wb_stb_o;
      if (!wb_cyc_o && !rsp_valid) gaps++;
      wb_rty_i = wb_cyc_o && !wb_stb_o;
      if (rsp_valid) break;
      step();
    end
    slave_idle();
    checks += 4;
    if (pulses != 3) begin
      errors++; $display("FAIL rty_pulses got=%0d exp=3", pulses);
    end
    if (gaps != 2) begin
      errors++; $display("FAIL rty_gaps got=%0d exp=2", gaps);
    end
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10) begin
      errors++;
      $display("FAIL rty_status got=%b/%b exp=1/10",
               rsp_valid, rsp_status);
    end
    if (rsp_dat !== 32'd0) begin
      errors++; $display("FAIL rty_dat got=%h exp=0", rsp_dat);
    end
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    slave_idle();
    issue(1'b0, 32'h0000_0300, 32'h0, 4'hF);
    for (int i = 0; i < 40; i++) begin
      if (wb_cyc_o) n++;
      if (rsp_valid) break;
      step();
    end
    checks += 3;
    if (n != 16) begin
      errors++; $display("FAIL tmo_cyc_cycles got=%0d exp=16", n);
    end
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b11) begin
      errors++;
      $display("FAIL tmo_status got=%b/%b exp=1/11",
               rsp_valid, rsp_status);
    end
    if (wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL tmo_cyc_low got=%b exp=0", wb_cyc_o);
    end
    step();
    issue(1'b1, 32'h0000_0304, 32'h0BAD_F00D, 4'hF);
    for (int i = 0; i < 20; i++) begin
      wb_ack_i = wb_cyc_o && !wb_stb_o;
      if (rsp_valid) break;
      step();
    end
    wb_ack_i = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00) begin
      errors++;
      $display("FAIL tmo_next_cmd got=%b/%b exp=1/00",
               rsp_valid, rsp_status);
    end
    step();
  endtask

  task automatic test_err_hold();
    logic bad = 1'b0;
    wb_dat_i  = 32'h1357_9BDF;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      wb_ack_i = wb_cyc_o && !wb_stb_o;
      wb_err_i = wb_cyc_o && !wb_stb_o;
      if (rsp_valid) break;
      step();
    end
    slave_idle();
    checks += 2;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b01) begin
      errors++;
      $display("FAIL err_status got=%b/%b exp=1/01",
               rsp_valid, rsp_status);
    end
    if (rsp_dat !== 32'd0) begin
      errors++; $display("FAIL err_dat got=%h exp=0", rsp_dat);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b01
          || rsp_dat !== 32'd0 || cmd_ready !== 1'b0
          || wb_cyc_o !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL err_hold_stable got=1 exp=0");
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_release got=%b/%b exp=0/1",
               rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int  hs[$];
    int  rv = -1;
    logic bad = 1'b0;
    wb_dat_i = 32'h0000_0042;
    cmd_we = 1'b0; cmd_adr = 32'h500;
    cmd_dat = 32'h0; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_valid && cmd_ready) hs.push_back(i);
      if (rsp_valid && rv < 0) rv = i;
      if (rsp_valid && wb_cyc_o) bad = 1'b1;
      wb_ack_i = wb_cyc_o && !wb_stb_o;
      step();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !(cmd_ready && !wb_cyc_o); i++) begin
      wb_ack_i = wb_cyc_o && !wb_stb_o;
      step();
    end
    wb_ack_i = 1'b0;
    checks += 3;
    if (hs.size() < 2 || hs[1] - hs[0] != 4) begin
      errors++;
      $display("FAIL b2b_period got=%0d exp=4",
               hs.size() < 2 ? -1 : hs[1] - hs[0]);
    end
    if (hs.size() < 1 || rv - hs[0] != 3) begin
      errors++;
      $display("FAIL b2b_latency got=%0d exp=3",
               hs.size() < 1 ? -1 : rv - hs[0]);
    end
    if (bad) begin
      errors++; $display("FAIL b2b_cyc_overlap got=1 exp=0");
    end
  endtask

  task automatic test_reset_mid();
    logic bad = 1'b0;
    slave_idle();
    issue(1'b0, 32'h0000_0600, 32'h0, 4'hF);
    step();
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_in_wait got=%b%b exp=10",
               wb_cyc_o, wb_stb_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rm_async_clear got=%b exp=000",
               {wb_cyc_o, wb_stb_o, rsp_valid});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rm_cmd_ready got=%b exp=1", cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || wb_cyc_o) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rm_spurious got=1 exp=0");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1;
    wb_dat_i = '0;
    slave_idle();
    step();
    step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_read();
    test_write_stall();
    test_retry();
    test_timeout();
    test_err_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
